// File: rtl/regfile_mp.sv
// Multi-port register file: two byte-masked write ports, NUM_RD combinational read ports,
// hardware clear sequence after reset. Define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [DATA_W/8-1:0]        wbe0,
    input  logic [DATA_W/8-1:0]        wbe1,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic                       ready
);

    localparam int NUM_REGS  = 2**ADDR_W;
    localparam int NUM_BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  w_cnt_next;
    logic               w_ready;
    logic               w_wr0;
    logic               w_wr1;

    // Entry 0 is never written and never observed; address 0 is hardwired to zero.
    logic [DATA_W-1:0]  r_regs [NUM_REGS];

    assign w_ready = (r_state == ST_READY);
    assign ready   = w_ready;

    // A write landing on the same edge as rst is dropped along with the restart.
    assign w_wr0 = w_ready && !rst && we0 && (waddr0 != '0);
    assign w_wr1 = w_ready && !rst && we1 && (waddr1 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= ADDR_W'(1);
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_next = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_READY;
                    w_cnt_next   = r_cnt;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = ADDR_W'(1);
            end
        endcase
    end

    // Port 1 is assigned last so it wins any byte both ports enable on the same address.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (w_wr0 && wbe0[b]) begin
                r_regs[waddr0][b*8 +: 8] <= wdata0[b*8 +: 8];
            end
            if (w_wr1 && wbe1[b]) begin
                r_regs[waddr1][b*8 +: 8] <= wdata1[b*8 +: 8];
            end
        end
    end

    genvar gi;
    genvar gj;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_stored;
            logic [DATA_W-1:0] w_val;

            assign w_addr   = raddr[gi*ADDR_W +: ADDR_W];
            assign w_stored = r_regs[w_addr];

`ifdef REGFILE_MP_BYPASS_EN
            // Forward in-flight write bytes with the same priority the array update uses.
            for (gj = 0; gj < NUM_BYTES; gj++) begin : g_byp
                logic w_hit0;
                logic w_hit1;
                assign w_hit0 = we0 && (waddr0 == w_addr) && wbe0[gj];
                assign w_hit1 = we1 && (waddr1 == w_addr) && wbe1[gj];
                assign w_val[gj*8 +: 8] = w_hit1 ? wdata1[gj*8 +: 8] :
                                          w_hit0 ? wdata0[gj*8 +: 8] :
                                                   w_stored[gj*8 +: 8];
            end
`else
            assign w_val = w_stored;
`endif

            assign rdata[gi*DATA_W +: DATA_W] =
                (re[gi] && w_ready && (w_addr != '0)) ? w_val : '0;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2).
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  wbe0, wbe1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .we0    (we0),
        .we1    (we1),
        .waddr0 (waddr0),
        .waddr1 (waddr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .wbe0   (wbe0),
        .wbe1   (wbe1),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
        wbe0 = '0; wbe1 = '0;
    endtask

    // Point both read ports at the same address, enabled, then let outputs settle.
    task automatic set_read(input logic [4:0] a);
        re = 2'b11;
        raddr = {a, a};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_writes();
        re = 2'b11;
        raddr = {5'd5, 5'd0};
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_low cycle %0d: got %b expected 0", i, ready);
            end
            n_checks++;
            if (rdata[31:0] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata_clear cycle %0d: got %h expected 00000000", i, rdata[31:0]);
            end
            tick();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high: got %b expected 1", ready);
        end
        for (int a = 1; a < 32; a++) begin
            set_read(5'(a));
            n_checks++;
            if (rdata !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_reg_zero reg %0d: got %h expected 0", a, rdata);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_byte_enable();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11223344; wbe0 = 4'hF;
        tick();
        wdata0 = 32'hAABBCCDD; wbe0 = 4'h5;
        tick();
        idle_writes();
        set_read(5'd5);
        n_checks++;
        if (rdata !== {32'h11BB33DD, 32'h11BB33DD}) begin
            n_fail++;
            $display("FAIL byte_enable reg5: got %h expected 11bb33dd on both ports", rdata);
        end
        $display("test_byte_enable done");
    endtask

    task automatic test_dual_write();
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h01020304; wbe0 = 4'hF;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hF0F0F0F0; wbe1 = 4'h3;
        tick();
        idle_writes();
        set_read(5'd7);
        n_checks++;
        if (rdata !== {32'h0102F0F0, 32'h0102F0F0}) begin
            n_fail++;
            $display("FAIL dual_write reg7: got %h expected 0102f0f0 on both ports", rdata);
        end
        $display("test_dual_write done");
    endtask

    task automatic test_addr0();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; wbe0 = 4'hF;
        tick();
        idle_writes();
        set_read(5'd0);
        n_checks++;
        if (rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL addr0_read: got %h expected 0", rdata);
        end
        re = 2'b11; raddr = {5'd7, 5'd5};
        #1;
        n_checks++;
        if (rdata !== {32'h0102F0F0, 32'h11BB33DD}) begin
            n_fail++;
            $display("FAIL addr0_no_side_effect: got %h expected 0102f0f011bb33dd", rdata);
        end
        $display("test_addr0 done");
    endtask

    task automatic test_wbe_zero_and_re();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hFFFFFFFF; wbe0 = 4'h0;
        set_read(5'd5);
        n_checks++;
        if (rdata[31:0] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL wbe_zero_same_cycle: got %h expected 11bb33dd", rdata[31:0]);
        end
        tick();
        idle_writes();
        re = 2'b01; raddr = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (rdata !== {32'h0, 32'h11BB33DD}) begin
            n_fail++;
            $display("FAIL re_gating: got %h expected 0000000011bb33dd", rdata);
        end
        $display("test_wbe_zero_and_re done");
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
`ifdef REGFILE_MP_BYPASS_EN
        exp_now = 32'hDEADBEEF;
`else
        exp_now = 32'h00000000;
`endif
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF; wbe0 = 4'hF;
        set_read(5'd3);
        n_checks++;
        if (rdata !== {exp_now, exp_now}) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h expected %h on both ports", rdata, exp_now);
        end
        tick();
        idle_writes();
        #1;
        n_checks++;
        if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h expected deadbeef on both ports", rdata);
        end
        $display("test_bypass done");
    endtask

    task automatic test_back_to_back();
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA5A5A5A5; wbe0 = 4'hF;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h5A5A5A5A; wbe1 = 4'hF;
        tick();
        waddr0 = 5'd12; wdata0 = 32'h12121212; wbe0 = 4'hF;
        waddr1 = 5'd10; wdata1 = 32'hC3C3C3C3; wbe1 = 4'hC;
        tick();
        idle_writes();
        re = 2'b11; raddr = {5'd11, 5'd10};
        #1;
        n_checks++;
        if (rdata !== {32'h5A5A5A5A, 32'hC3C3A5A5}) begin
            n_fail++;
            $display("FAIL b2b_r10_r11: got %h expected 5a5a5a5ac3c3a5a5", rdata);
        end
        set_read(5'd12);
        n_checks++;
        if (rdata[63:32] !== 32'h12121212) begin
            n_fail++;
            $display("FAIL b2b_r12: got %h expected 12121212", rdata[63:32]);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678; wbe0 = 4'hF;
        tick();
        set_read(5'd9);
        n_checks++;
        if (rdata[31:0] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mid_reset_pre_write: got %h expected 12345678", rdata[31:0]);
        end
        // Write coincident with the reset edge must be dropped.
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hCAFEF00D; wbe0 = 4'hF;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            we0 = 1'b1; wbe0 = 4'hF; wdata0 = 32'hFFFF0000 | 32'(i);
            waddr0 = (i % 2 == 1) ? 5'd2 : 5'd30;
            we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0BADC0DE; wbe1 = 4'hF;
            #1;
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_ready_low cycle %0d: got %b expected 0", i, ready);
            end
            tick();
        end
        idle_writes();
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready_high: got %b expected 1", ready);
        end
        for (int a = 1; a < 32; a++) begin
            set_read(5'(a));
            n_checks++;
            if (rdata !== 64'h0) begin
                n_fail++;
                $display("FAIL mid_reset_reg_zero reg %0d: got %h expected 0", a, rdata);
            end
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        rst = 1'b1;
        idle_writes();
        re = '0;
        raddr = '0;
        test_reset();
        test_byte_enable();
        test_dual_write();
        test_addr0();
        test_wbe_zero_and_re();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
